// File: rtl/io_route_sched.sv
// Round-robin scheduler for a shared registered mux/demux route; holds each route HOLD cycles.
// Optional index range check enabled by defining IO_ROUTE_RANGE_CHK_EN (default: disabled, err tied low).
//
// state  | meaning
// IDLE   | waiting; req sampled and arbitrated here only
// XFER   | route live on mux_sel/demux_sel for HOLD cycles
// DONE   | route finished, done pulse, back to IDLE next cycle
module io_route_sched #(
    parameter int NREQ  = 4,
    parameter int SEL_W = 10,
    parameter int HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SEL_W-1:0]   req_src,
    input  logic [NREQ*SEL_W-1:0]   req_dst,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [SEL_W-1:0]        mux_sel,
    output logic [SEL_W-1:0]        demux_sel,
    output logic                    route_valid,
    output logic                    busy,
    output logic [NREQ-1:0]         err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  last_gnt;
    logic [IDX_W-1:0]  cur;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   err_q;
    logic [SEL_W-1:0]  mux_q;
    logic [SEL_W-1:0]  demux_q;
    logic              rv_q;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic [SEL_W-1:0]  win_src;
    logic [SEL_W-1:0]  win_dst;
    logic              win_bad;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_src = req_src[int'(win_idx)*SEL_W +: SEL_W];
    assign win_dst = req_dst[int'(win_idx)*SEL_W +: SEL_W];

`ifdef IO_ROUTE_RANGE_CHK_EN
    assign win_bad = (32'(win_src) > 32'd511) || (32'(win_dst) > 32'd511);
`else
    assign win_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last_gnt <= IDX_W'(NREQ - 1);
            cur      <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            mux_q    <= '0;
            demux_q  <= '0;
            rv_q     <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        last_gnt <= win_idx;
                        cur      <= win_idx;
                        gnt_q    <= ONE << win_idx;
                        cnt      <= '0;
                        if (win_bad) begin
                            // Rejected route: skip XFER, leave sels untouched.
                            err_q <= ONE << win_idx;
                            state <= S_DONE;
                        end else begin
                            mux_q   <= win_src;
                            demux_q <= win_dst;
                            rv_q    <= 1'b1;
                            state   <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (cnt == CNT_LAST) begin
                        state  <= S_DONE;
                        rv_q   <= 1'b0;
                        done_q <= ONE << cur;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    // A rejected route pulses done one cycle after its gnt/err.
                    if (|err_q) done_q <= ONE << cur;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mux_sel     = mux_q;
    assign demux_sel   = demux_q;
    assign route_valid = rv_q;
    assign busy        = (state != S_IDLE);

endmodule
